// File: rtl/dadder_pkg.sv
// -----------------------------------------------------------------------------
// dadder_pkg
// Shared constants and types for the dadder result path.
//   DADDER_DATA_WIDTH_DEFAULT : default adder result width
//   DADDER_DROP_CNT_W         : width of the dropped-result counter
//   DADDER_OF_CNT_W           : width of the optional overflow-push counter
//   dadder_entry_t            : {of, data} record at the default result width
// -----------------------------------------------------------------------------
package dadder_pkg;

  localparam int DADDER_DATA_WIDTH_DEFAULT = 8;
  localparam int DADDER_DROP_CNT_W         = 8;
  localparam int DADDER_OF_CNT_W           = 16;

  typedef struct packed {
    logic                                 of;
    logic [DADDER_DATA_WIDTH_DEFAULT-1:0] data;
  } dadder_entry_t;

endpackage : dadder_pkg

// File: rtl/dadder_rsp_mem.sv
// -----------------------------------------------------------------------------
// dadder_rsp_mem
// DEPTH x (DATA_WIDTH+1) entry storage for the response FIFO. Synchronous
// write, asynchronous read. Contents are not reset; the FIFO masks its output
// while empty, so stale entries are never observed.
// Ports:
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write entry index
//   wr_data  : {of, data} entry to store
//   rd_addr  : read entry index
//   rd_data  : {of, data} entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module dadder_rsp_mem #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_WIDTH:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_WIDTH:0] rd_data
);

  logic [DATA_WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : dadder_rsp_mem

// File: rtl/dadder_rsp_fifo.sv
// -----------------------------------------------------------------------------
// dadder_rsp_fifo
// Response FIFO behind the dadder. The upstream adder cannot be stalled, so a
// result arriving while the FIFO is full (and not popping) is discarded and
// counted in drop_cnt. Head is registered: a push becomes visible one cycle
// later, there is no input-to-output bypass.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   in_vld    : upstream result valid (no backpressure)
//   in_of     : upstream overflow/negative flag
//   in_data   : upstream result
//   out_vld   : head entry valid (level != 0)
//   out_ready : consumer accepts head entry
//   out_of    : head entry flag (0 while empty)
//   out_data  : head entry data (0 while empty)
//   level     : occupancy, 0..DEPTH
//   full      : level == DEPTH
//   drop_cnt  : results dropped while full, saturating
//   of_cnt    : pushes with in_of==1, saturating; present only when
//               DADDER_RSP_FIFO_STATS_EN is defined
// -----------------------------------------------------------------------------
module dadder_rsp_fifo
  import dadder_pkg::*;
#(
  parameter  int DATA_WIDTH = DADDER_DATA_WIDTH_DEFAULT,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_vld,
  input  logic                         in_of,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_vld,
  input  logic                         out_ready,
  output logic                         out_of,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [LVL_W-1:0]             level,
  output logic                         full,
  output logic [DADDER_DROP_CNT_W-1:0] drop_cnt
`ifdef DADDER_RSP_FIFO_STATS_EN
  ,
  output logic [DADDER_OF_CNT_W-1:0]   of_cnt
`endif
);

  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic [DADDER_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                in_vld_s;
  logic                out_ready_s;
  logic                push;
  logic                pop;
  logic                drop;
  logic [DATA_WIDTH:0] rd_entry;

  // Case equality folds X/Z on the handshake inputs to "not asserted".
  assign in_vld_s    = (in_vld === 1'b1);
  assign out_ready_s = (out_ready === 1'b1);

  assign full    = (level_q == LVL_W'(DEPTH));
  assign out_vld = (level_q != '0);

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop  = out_vld & out_ready_s;
  assign push = in_vld_s & (~full | pop);
  assign drop = in_vld_s & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DADDER_DROP_CNT_W'(1);
    if (!reset_n) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    level_q    <= level_d;
    drop_cnt_q <= drop_cnt_d;
  end

  // Writes are suppressed during reset so a same-cycle push leaves no trace.
  dadder_rsp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & reset_n),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_of, in_data}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  // Storage is never cleared, so the head is masked while empty.
  assign out_data = out_vld ? rd_entry[DATA_WIDTH-1:0] : '0;
  assign out_of   = out_vld & rd_entry[DATA_WIDTH];
  assign level    = level_q;
  assign drop_cnt = drop_cnt_q;

`ifdef DADDER_RSP_FIFO_STATS_EN
  logic [DADDER_OF_CNT_W-1:0] of_cnt_q, of_cnt_d;

  always_comb begin
    of_cnt_d = of_cnt_q;
    if (push && in_of && (of_cnt_q != '1)) of_cnt_d = of_cnt_q + DADDER_OF_CNT_W'(1);
    if (!reset_n) of_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    of_cnt_q <= of_cnt_d;
  end

  assign of_cnt = of_cnt_q;
`else
  // Statistics counter not built.
`endif

endmodule : dadder_rsp_fifo

// File: tb/tb_dadder_rsp_fifo.sv
module tb_dadder_rsp_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_vld;
  logic       in_of;
  logic [7:0] in_data;
  logic       out_vld;
  logic       out_ready;
  logic       out_of;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       full;
  logic [7:0] drop_cnt;
`ifdef DADDER_RSP_FIFO_STATS_EN
  logic [15:0] of_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dadder_rsp_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld    (in_vld),
    .in_of     (in_of),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_ready (out_ready),
    .out_of    (out_of),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .drop_cnt  (drop_cnt)
`ifdef DADDER_RSP_FIFO_STATS_EN
    ,
    .of_cnt    (of_cnt)
`endif
  );

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_vld = 1'b0; in_of = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++;
    if (out_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_out_vld: got %0b expected 0", out_vld); end
    tests_run++;
    if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", full); end
    tests_run++;
    if (out_data !== 8'h00 || out_of !== 1'b0) begin
      tests_failed++; $display("FAIL reset_head: got data=%0h of=%0b expected 0/0", out_data, out_of);
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single_push();
    in_vld = 1'b1; in_of = 1'b0; in_data = 8'h12;
    #1;
    tests_run++;
    if (out_vld !== 1'b0) begin tests_failed++; $display("FAIL single_no_bypass: got out_vld=%0b expected 0", out_vld); end
    step();
    in_vld = 1'b0;
    tests_run++;
    if (out_vld !== 1'b1 || out_data !== 8'h12 || out_of !== 1'b0 || level !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_head: got vld=%0b data=%0h of=%0b level=%0d expected 1/12/0/1",
               out_vld, out_data, out_of, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || out_vld !== 1'b0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_pop: got level=%0d vld=%0b data=%0h expected 0/0/00", level, out_vld, out_data);
    end
  endtask

  task automatic test_fill_drop();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_vld = 1'b1; in_data = 8'(i); in_of = 1'(i & 1);
      step();
      if (i == 4) begin
        tests_run++;
        if (full !== 1'b1 || level !== 3'd4) begin
          tests_failed++; $display("FAIL fill_full: got full=%0b level=%0d expected 1/4", full, level);
        end
      end
    end
    in_vld = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd1) begin tests_failed++; $display("FAIL fill_drop: got %0d expected 1", drop_cnt); end
    // Head must hold while not accepted.
    step(); step();
    tests_run++;
    if (out_data !== 8'h01 || out_of !== 1'b1) begin
      tests_failed++; $display("FAIL fill_hold: got data=%0h of=%0b expected 01/1", out_data, out_of);
    end
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (out_vld !== 1'b1 || out_data !== 8'(i) || out_of !== 1'(i & 1)) begin
        tests_failed++;
        $display("FAIL drain_order[%0d]: got vld=%0b data=%0h of=%0b expected 1/%0h/%0b",
                 i, out_vld, out_data, out_of, i, i & 1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    tests_run++;
    if (level !== 3'd0 || out_vld !== 1'b0) begin
      tests_failed++; $display("FAIL drain_empty: got level=%0d vld=%0b expected 0/0", level, out_vld);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h23; exp_q[2] = 8'h24; exp_q[3] = 8'h99;
    out_ready = 1'b0; in_of = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 8'h21 + 8'(i);
      step();
    end
    in_vld = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    step();
    in_vld = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd4 || full !== 1'b1 || drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL full_push_pop: got level=%0d full=%0b drop=%0d expected 4/1/1", level, full, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_data !== exp_q[i]) begin
        tests_failed++; $display("FAIL full_push_pop_order[%0d]: got %0h expected %0h", i, out_data, exp_q[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_drop_saturate();
    out_ready = 1'b0; in_of = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 8'h30 + 8'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      in_vld = 1'b1; in_data = 8'hEE;
      step();
    end
    in_vld = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd255) begin tests_failed++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
    tests_run++;
    if (out_data !== 8'h30 || level !== 3'd4) begin
      tests_failed++; $display("FAIL drop_keeps_data: got data=%0h level=%0d expected 30/4", out_data, level);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_of = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        tests_run++;
        if (out_vld !== 1'b1 || out_data !== 8'h40 + 8'(i - 1) || level !== 3'd1) begin
          tests_failed++;
          $display("FAIL wrap[%0d]: got vld=%0b data=%0h level=%0d expected 1/%0h/1",
                   i, out_vld, out_data, level, 8'h40 + 8'(i - 1));
        end
      end
      in_vld = 1'b1; in_data = 8'h40 + 8'(i);
      step();
    end
    in_vld = 1'b0;
    tests_run++;
    if (out_data !== 8'h49) begin tests_failed++; $display("FAIL wrap_last: got %0h expected 49", out_data); end
    step();
    out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL wrap_empty: got %0d expected 0", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_of = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_data = 8'h50 + 8'(i);
      step();
    end
    tests_run++;
    if (level !== 3'd3) begin tests_failed++; $display("FAIL mid_pre_level: got %0d expected 3", level); end
    // Reset coincides with a push and a pop; neither may take effect.
    reset_n = 1'b0; in_vld = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    step();
    reset_n = 1'b1; in_vld = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || out_vld !== 1'b0 || drop_cnt !== 8'd0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset: got level=%0d vld=%0b drop=%0d data=%0h expected 0/0/0/00",
               level, out_vld, drop_cnt, out_data);
    end
    step();
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL mid_reset_hold: got %0d expected 0", level); end
  endtask

  task automatic test_x_inputs();
    in_vld = 1'bx; out_ready = 1'bz; in_data = 8'hAB;
    step();
    in_vld = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || out_vld !== 1'b0) begin
      tests_failed++; $display("FAIL x_in_vld: got level=%0d vld=%0b expected 0/0", level, out_vld);
    end
  endtask

`ifdef DADDER_RSP_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_of = 1'b1; in_data = 8'hF0 + 8'(i);
      step();
    end
    in_vld = 1'b0; in_of = 1'b0;
    step();
    tests_run++;
    if (of_cnt !== 16'd3) begin tests_failed++; $display("FAIL of_cnt: got %0d expected 3", of_cnt); end
    do_reset();
    out_ready = 1'b0;
    tests_run++;
    if (of_cnt !== 16'd0) begin tests_failed++; $display("FAIL of_cnt_reset: got %0d expected 0", of_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill_drop();
    test_full_push_pop();
    test_drop_saturate();
    test_wrap();
    test_reset_mid();
    test_x_inputs();
`ifdef DADDER_RSP_FIFO_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dadder_rsp_fifo

// File: doc/dadder_rsp_fifo.md
DADDER_RSP_FIFO -- requirements
Module: dadder_rsp_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning result data width; it SHALL match the upstream adder.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entry count; it SHALL be a power of two, >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_vld, input, 1 bit: upstream result valid; it has no backpressure.
REQ-006 The block SHALL have port in_of, input, 1 bit: upstream overflow/negative flag.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: upstream result.
REQ-008 The block SHALL have port out_vld, output, 1 bit: head entry valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-010 The block SHALL have port out_of, output, 1 bit: head entry flag.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: head entry data.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-013 The block SHALL have port full, output, 1 bit: level == DEPTH.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: count of results dropped while full.

Function
REQ-015 A push SHALL occur on a cycle where in_vld==1 and (full==0 or a pop occurs in the same cycle).
REQ-016 A pop SHALL occur on a cycle where out_vld==1 and out_ready==1.
REQ-017 out_vld SHALL equal (level != 0); out_of/out_data SHALL present the oldest entry.
REQ-018 Latency SHALL be one cycle: an entry pushed in cycle N is visible at the head no earlier than cycle N+1; there is no combinational bypass.
REQ-019 On an empty FIFO with a simultaneous push, out_vld SHALL stay 0 that cycle and rise in the next cycle.
REQ-020 On a full FIFO with a simultaneous push and pop, both SHALL occur and level SHALL remain DEPTH.
REQ-021 If in_vld==1, full==1 and no pop occurs, the result SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-023 level SHALL update as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-024 out_data/out_of SHALL hold stable while out_vld==1 and out_ready==0.
REQ-025 An X/Z value on in_vld or out_ready SHALL be treated as 0.

Reset
REQ-026 On reset, level, pointers and drop_cnt SHALL clear to 0, and out_vld, full, out_of and out_data SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries and any same-cycle push or pop, with no partial update.
REQ-028 Storage contents need not be cleared; out_data SHALL be masked to 0 while empty.

Configuration
REQ-029 When macro DADDER_RSP_FIFO_STATS_EN is defined, the block SHALL add output of_cnt [15:0], counting pushes with in_of==1, saturating at 65535 and cleared by reset.
REQ-030 When DADDER_RSP_FIFO_STATS_EN is undefined, the of_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package dadder_pkg SHALL hold DADDER_DATA_WIDTH_DEFAULT = 8, DADDER_DROP_CNT_W = 8, DADDER_OF_CNT_W = 16, and a typedef for the {of, data} entry record.
REQ-032 One sub-module, dadder_rsp_mem, SHALL hold DEPTH x (DATA_WIDTH+1) storage with a synchronous write port and an asynchronous read port.
REQ-033 Pointer, level and counter logic SHALL reside in dadder_rsp_fifo.

Verification
REQ-034 Bench SHALL cover: reset, then push 0x12/of=0 in cycle 0 -> out_vld=1, out_data=0x12, out_of=0 in cycle 1; level=1.
REQ-035 Bench SHALL cover: with out_ready=0, push 0x01..0x05 on consecutive cycles -> full=1 after 4 pushes, drop_cnt=1, then drain order 0x01,0x02,0x03,0x04.
REQ-036 Bench SHALL cover: with full=1, drive in_vld and out_ready together with in_data=0x99 -> level stays 4, drop_cnt unchanged, 0x99 emerges last.
REQ-037 Bench SHALL cover: 300 pushes while full with out_ready=0 -> drop_cnt saturates at 255.
REQ-038 Bench SHALL cover: 10 push/pop cycles with DEPTH=4 -> pointers wrap, and data out equals data in, in order.
REQ-039 Bench SHALL cover: reset asserted with level=3 -> next cycle level=0, out_vld=0, drop_cnt=0; with STATS_EN, 3 pushes with in_of=1 then reset -> of_cnt shows 3, then 0.
